fir_filter_mc: RTL and testbench

//  Parametrised multi-channel FIR filter. Successor to the fixed 3-channel, 24-bit filter.
//  One time-shared MAC serves NUM_CH channels over a common coefficient set.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_mac_unit.sv | 34 +++
 rtl/fir_filter_mc.sv | 125 ++++++++++++
 tb/tb_fir_filter_mc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the multi-channel FIR filter.
// sat_round works on a wide signed container so one definition serves every parameter set.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, MAC, OUT} state_t;

    localparam int MAX_W = 128;

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Round half up by COEF_FRAC bits, then clamp to the signed data_w range.
    function automatic logic signed [MAX_W-1:0] sat_round(input logic signed [MAX_W-1:0] acc,
                                                          input int data_w, input int frac);
        logic signed [MAX_W-1:0] one, r, hi, lo;
        one = 1;
        r   = acc;
        if (frac > 0) r = acc + (one <<< (frac - 1));
        r  = r >>> frac;
        hi = (one <<< (data_w - 1)) - one;
        lo = -(one <<< (data_w - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered multiply-accumulate: sum is the next accumulator value, acc holds it when enabled.
// clr restarts the accumulation from the current product.
module fir_mac_unit #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 17,
    parameter int PROD_W = 40,
    parameter int ACC_W  = 46
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [DATA_W+COEF_W-1:0] full;
    logic signed [PROD_W-1:0]        prod;
    logic signed [ACC_W-1:0]         acc;
    logic signed [ACC_W-1:0]         base;

    // Coefficients never exceed +/-2^(PROD_W-DATA_W-1) in magnitude, so this narrowing is lossless.
    assign full = a * b;
    assign prod = PROD_W'(full);
    assign base = clr ? '0 : acc;
    assign sum  = base + ACC_W'(prod);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   acc <= '0;
        else if (en) acc <= sum;
    end

endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel FIR filter: one time-shared MAC walks channel-major over all taps per frame.
// Frames enter and leave over valid/ready; coefficients are writable while idle.
module fir_filter_mc
    import fir_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 16,
    parameter int NUM_TAPS  = 33,
    parameter int COEF_FRAC = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    input  logic                       coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       busy
);

    localparam int ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One extra coefficient bit so the reset value of exactly +1.0 is representable.
    localparam int CW     = COEF_W + 1;
    localparam logic signed [CW-1:0] COEF_ONE = CW'(1 << COEF_FRAC);

    state_t state, state_next;
    logic [CH_W-1:0]          ch_cnt;
    logic [ADDR_W-1:0]        tap_cnt;
    logic signed [DATA_W-1:0] line [NUM_CH][NUM_TAPS];
    logic signed [CW-1:0]     coef [NUM_TAPS];
    logic [NUM_CH*DATA_W-1:0] frame_p0;
    logic signed [ACC_W-1:0]  mac_sum;
    logic accept, coef_take, tap_last, ch_last, mac_en;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign coef_take = coef_we && (state == IDLE) && ({1'b0, coef_addr} < (ADDR_W+1)'(NUM_TAPS));
    assign tap_last  = (tap_cnt == ADDR_W'(NUM_TAPS - 1));
    assign ch_last   = (ch_cnt == CH_W'(NUM_CH - 1));
    assign mac_en    = (state == MAC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   state_next = MAC;
            MAC:     if (tap_last && ch_last) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: frame capture on accept, delay-line shift and coefficient RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_p0 <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int t = 0; t < NUM_TAPS; t++)
                    line[c][t] <= '0;
            for (int t = 0; t < NUM_TAPS; t++)
                coef[t] <= (t == 0) ? COEF_ONE : '0;
        end else begin
            if (accept)    frame_p0 <= in_data;
            if (coef_take) coef[coef_addr] <= CW'(coef_data);
            if (state == SHIFT) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int t = NUM_TAPS - 1; t > 0; t--)
                        line[c][t] <= line[c][t-1];
                    line[c][0] <= frame_p0[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    fir_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (CW),
        .PROD_W (DATA_W + COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .en    (mac_en),
        .clr   (tap_cnt == '0),
        .a     (line[ch_cnt][tap_cnt]),
        .b     (coef[tap_cnt]),
        .sum   (mac_sum)
    );

    // Stage p1: the final sum of a channel is rounded straight into its output slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_cnt   <= '0;
            tap_cnt  <= '0;
            out_data <= '0;
        end else if (state == SHIFT) begin
            ch_cnt  <= '0;
            tap_cnt <= '0;
        end else if (state == MAC) begin
            if (tap_last) begin
                tap_cnt <= '0;
                ch_cnt  <= ch_cnt + CH_W'(1);
                out_data[ch_cnt*DATA_W +: DATA_W] <=
                    DATA_W'(sat_round(MAX_W'(mac_sum), DATA_W, COEF_FRAC));
            end else begin
                tap_cnt <= tap_cnt + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Scoreboard bench for fir_filter_mc: a direct-form FIR model predicts each accepted frame,
// a monitor compares every output handshake against the predictions in order.
module tb_fir_filter_mc;

    localparam int NUM_CH    = 3;
    localparam int DATA_W    = 24;
    localparam int COEF_W    = 16;
    localparam int NUM_TAPS  = 33;
    localparam int COEF_FRAC = 15;
    localparam int FW        = NUM_CH * DATA_W;
    localparam longint MAXV  = 8388607;
    localparam longint MINV  = -8388608;

    logic clk = 0;
    logic reset;
    logic in_valid, in_ready, out_valid, out_ready, coef_we, busy;
    logic [FW-1:0] in_data, out_data;
    logic [5:0] coef_addr;
    logic [COEF_W-1:0] coef_data;

    int errors = 0, checks = 0, frames_out = 0;
    bit rand_rdy = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] mon_exp, last_out;
    int coef_m [NUM_TAPS];
    int hist [NUM_CH][NUM_TAPS];

    fir_filter_mc #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .COEF_W(COEF_W),
        .NUM_TAPS(NUM_TAPS), .COEF_FRAC(COEF_FRAC)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pack3(input int a, input int b, input int c);
        return {DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NUM_TAPS; t++) coef_m[t] = (t == 0) ? (1 << COEF_FRAC) : 0;
        for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t < NUM_TAPS; t++) hist[c][t] = 0;
        exp_q.delete();
    endtask

    // y[n] = clamp(round_half_up(sum_t h[t]*x[n-t] / 2^COEF_FRAC)) per channel.
    task automatic model_push(input logic [FW-1:0] f);
        logic [FW-1:0] e;
        logic signed [DATA_W-1:0] s;
        longint acc, y;
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int t = NUM_TAPS - 1; t > 0; t--) hist[c][t] = hist[c][t-1];
            s = f[c*DATA_W +: DATA_W];
            hist[c][0] = int'(s);
            acc = 0;
            for (int t = 0; t < NUM_TAPS; t++) acc += longint'(hist[c][t]) * longint'(coef_m[t]);
            y = (acc + (longint'(1) <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
            if (y > MAXV) y = MAXV;
            if (y < MINV) y = MINV;
            e[c*DATA_W +: DATA_W] = DATA_W'(y);
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [FW-1:0] f);
        int n = 0;
        @(negedge clk);
        in_data  = f;
        in_valid = 1;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
            in_valid = 0;
            return;
        end
        model_push(f);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic write_coef(input int addr, input int val, input bit taken);
        logic signed [COEF_W-1:0] v;
        v = COEF_W'(val);
        @(negedge clk);
        coef_we   = 1;
        coef_addr = 6'(addr);
        coef_data = v;
        if (taken && addr < NUM_TAPS) coef_m[addr] = int'(v);
        @(posedge clk); #1;
        coef_we = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 20000) begin @(posedge clk); #1; n++; end
        check("drain_done", (n < 20000), 1);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    // Monitor: every output handshake pops and compares one prediction.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            frames_out++;
            last_out = out_data;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame actual=%0h required=none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    errors++;
                    $display("FAIL frame actual=%0h required=%0h", out_data, mon_exp);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad, f0;
        logic [FW-1:0] held;
        reset = 1; in_valid = 0; in_data = '0; out_ready = 1;
        coef_we = 0; coef_addr = '0; coef_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        reset = 0;

        // Identity after reset, with accept-to-valid latency.
        send(pack3(5, -7, 1));
        check("busy_after_accept", {busy, in_ready}, 2'b10);
        lat = 1;
        while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
        check("latency", lat, 101);
        drain();
        check("identity_out", last_out, pack3(5, -7, 1));

        // Impulse response through ramp coefficients; out-of-range address ignored.
        do_reset();
        for (int t = 0; t < NUM_TAPS; t++) write_coef(t, t + 1, 1);
        write_coef(40, 12345, 1);
        send(pack3(32768, 0, 0));
        repeat (NUM_TAPS - 1) send('0);
        drain();
        check("impulse_last", last_out, pack3(NUM_TAPS, 0, 0));

        // Saturation at both rails.
        do_reset();
        for (int t = 0; t < NUM_TAPS; t++) write_coef(t, 32767, 1);
        repeat (NUM_TAPS) send(pack3(8388607, 8388607, 8388607));
        drain();
        check("sat_pos", last_out, pack3(8388607, 8388607, 8388607));
        repeat (NUM_TAPS) send(pack3(-8388608, -8388608, -8388608));
        drain();
        check("sat_neg", last_out, pack3(-8388608, -8388608, -8388608));

        // Random coefficients and samples under random backpressure.
        do_reset();
        for (int t = 0; t < NUM_TAPS; t++) write_coef(t, int'($urandom_range(0, 65535)), 1);
        rand_rdy = 1;
        repeat (25) send(pack3(int'($urandom), int'($urandom), int'($urandom)));
        drain();
        rand_rdy = 0;
        @(posedge clk); #1;
        out_ready = 1;

        // Long backpressure with the next frame waiting at the input.
        do_reset();
        f0 = frames_out;
        out_ready = 0;
        send(pack3(111, -222, 333));
        lat = 0;
        while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
        check("bp_valid_seen", out_valid, 1);
        held = out_data;
        in_data = pack3(44, 45, 46);
        in_valid = 1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("bp_hold", bad, 0);
        @(posedge clk); #1;
        out_ready = 1;
        send(pack3(44, 45, 46));
        drain();
        check("bp_frames", frames_out - f0, 2);

        // Coefficient write while busy is dropped; while idle it takes effect.
        send(pack3(100, 200, 300));
        repeat (20) @(posedge clk);
        write_coef(0, 0, 0);
        send(pack3(11, 22, 33));
        drain();
        check("busy_write_dropped", last_out, pack3(11, 22, 33));
        write_coef(0, 0, 1);
        send(pack3(44, 55, 66));
        drain();
        check("idle_write_zero", last_out, 0);

        // Reset in the middle of MAC.
        do_reset();
        write_coef(5, 1000, 1);
        send(pack3(9, 9, 9));
        repeat (39) @(posedge clk);
        #3;
        reset = 1;
        model_reset();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_idle", {in_ready, busy}, 2'b10);
        check("midrst_out_data", out_data, 0);
        @(negedge clk);
        reset = 0;
        send(pack3(3, 3, 3));
        drain();
        check("midrst_identity", last_out, pack3(3, 3, 3));
        write_coef(2, 16384, 1);
        send(pack3(7, 7, 7));
        send(pack3(1, 1, 1));
        drain();
        check("midrst_lines_clear", last_out, pack3(3, 3, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
